// File: rtl/felix_pack_pkg.sv
// Shared constants and types for the FELIX TX lane packer.
package felix_pack_pkg;

   localparam logic [7:0]  K28_5         = 8'hBC;
   localparam logic [31:0] IDLE_WORD_DEF = {24'h000000, K28_5};
   localparam logic [3:0]  IDLE_K_DEF    = 4'b0001;

   localparam int WORD_W = 32;
   localparam int K_W    = 4;
   localparam int LANE_W = WORD_W + K_W;

   typedef enum logic {
      ST_EMPTY   = 1'b0,
      ST_PARTIAL = 1'b1
   } asm_state_t;

endpackage

// File: rtl/felix_sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding completed packer beats.
// rdata reads as zero whenever the FIFO is empty.
module felix_sync_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign valid   = (level != '0);
   assign full    = (level == LW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & valid;
   assign rdata   = valid ? mem[rd_ptr] : '0;

   // Storage array; no reset needed since reads are gated by valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy; simultaneous push and pop leaves level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/felix_lane_packer.sv
// FELIX TX lane packer: assembles LANES 32-bit words (+4-bit K-flags) into
// one wide beat and queues completed beats in a FWFT FIFO.
// Optional build macro FELIX_PACK_FLUSH_EN enables idle-fill flushing of a
// partial beat after FLUSH_CYCLES idle cycles.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_EMPTY   | no words held, next accept lands in lane 0
// ST_PARTIAL | 1..LANES-1 words held, lane_q points at next lane
module felix_lane_packer
   import felix_pack_pkg::*;
#(
   parameter int          LANES        = 2,
   parameter int          DEPTH        = 8,
   parameter int          FLUSH_CYCLES = 16,
   parameter logic [31:0] IDLE_WORD    = IDLE_WORD_DEF,
   parameter logic [3:0]  IDLE_K       = IDLE_K_DEF
) (
   input  logic                        clk240,
   input  logic                        rst_n,
   input  logic [31:0]                 in_data,
   input  logic [3:0]                  in_k,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [LANES*32-1:0]         out_data,
   output logic [LANES*4-1:0]          out_k,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(DEPTH):0]      fifo_level,
   output logic [15:0]                 flush_cnt
);

   localparam int LIW = $clog2(LANES);
   localparam int DW  = LANES * WORD_W;
   localparam int KW  = LANES * K_W;
   localparam int BW  = LANES * LANE_W;
   localparam logic [LIW-1:0] LAST_LANE = LIW'(LANES - 1);

   if (LANES < 2) begin : g_bad_lanes
      $error("felix_lane_packer: LANES must be at least 2");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("felix_lane_packer: DEPTH must be a power of two, at least 2");
   end
   if (FLUSH_CYCLES < 1) begin : g_bad_flush
      $error("felix_lane_packer: FLUSH_CYCLES must be at least 1");
   end

   asm_state_t     state_q, state_d;
   logic [LIW-1:0] lane_q, lane_d;
   logic [DW-1:0]  asm_data_q;
   logic [KW-1:0]  asm_k_q;
   logic [DW-1:0]  beat_data;
   logic [KW-1:0]  beat_k;
   logic           ready_q;
   logic           accept;
   logic           push;
   logic           flush_fire;
   logic           fifo_full;
   logic [BW-1:0]  fifo_rdata;

   // in_ready is held low through reset and the first edge after it; it
   // never depends on out_ready, so a pop at full frees space one cycle later.
   assign in_ready = ready_q & ~fifo_full;
   assign accept   = in_valid & in_ready;

   // Ready qualifier: low during reset, high from the first clock after.
   always_ff @(posedge clk240 or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b0;
      else        ready_q <= 1'b1;
   end

   // Assembler state, lane pointer and partial-beat register.
   always_ff @(posedge clk240 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         lane_q     <= '0;
         asm_data_q <= '0;
         asm_k_q    <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         if (accept) begin
            asm_data_q <= beat_data;
            asm_k_q    <= beat_k;
         end
      end
   end

   // Next-state: a push (full beat or flush) always returns to lane 0.
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      if (push) begin
         state_d = ST_EMPTY;
         lane_d  = '0;
      end else if (accept) begin
         state_d = ST_PARTIAL;
         lane_d  = lane_q + LIW'(1);
      end
   end

   // Beat formation: merge the incoming word into its lane, or pad the
   // unfilled lanes with the idle symbol when flushing.
   always_comb begin
      beat_data = asm_data_q;
      beat_k    = asm_k_q;
      for (int i = 0; i < LANES; i++) begin
         if (accept && (LIW'(i) == lane_q)) begin
            beat_data[i*WORD_W +: WORD_W] = in_data;
            beat_k[i*K_W +: K_W]          = in_k;
         end else if (flush_fire && (LIW'(i) >= lane_q)) begin
            beat_data[i*WORD_W +: WORD_W] = IDLE_WORD;
            beat_k[i*K_W +: K_W]          = IDLE_K;
         end
      end
      push = (accept && (lane_q == LAST_LANE)) || flush_fire;
   end

`ifdef FELIX_PACK_FLUSH_EN
   localparam int CW = $clog2(FLUSH_CYCLES + 1);

   logic [CW-1:0] idle_q;
   logic [15:0]   flush_cnt_q;

   // Accept on the threshold cycle wins; a full FIFO holds the flush off.
   assign flush_fire = (state_q == ST_PARTIAL) && !accept &&
                       (idle_q == CW'(FLUSH_CYCLES)) && !fifo_full;
   assign flush_cnt  = flush_cnt_q;

   // Idle counter saturates at the threshold while waiting for FIFO space.
   always_ff @(posedge clk240 or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
      end else if ((state_q == ST_PARTIAL) && !accept) begin
         if (flush_fire)                        idle_q <= '0;
         else if (idle_q != CW'(FLUSH_CYCLES))  idle_q <= idle_q + CW'(1);
      end else begin
         idle_q <= '0;
      end
   end

   // Saturating count of flushed partial beats.
   always_ff @(posedge clk240 or negedge rst_n) begin
      if (!rst_n)                                    flush_cnt_q <= '0;
      else if (flush_fire && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
   end
`else
   assign flush_fire = 1'b0;
   assign flush_cnt  = '0;
`endif

   felix_sync_fifo #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk240),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({beat_k, beat_data}),
      .pop   (out_ready),
      .rdata (fifo_rdata),
      .valid (out_valid),
      .full  (fifo_full),
      .level (fifo_level)
   );

   assign out_data = fifo_rdata[DW-1:0];
   assign out_k    = fifo_rdata[BW-1 -: KW];

endmodule
